// File: rtl/vtg_sel_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vtg_sel_arb                                                |
// | Description : Two-source round-robin stream arbiter with minimum grant   |
// |               dwell. It drives the select of the downstream vtg_mux and  |
// |               registers accepted beats into a one-entry output stage.    |
// |               Optional macro VTG_SEL_ARB_LOCK_EN adds a lock input that  |
// |               freezes the current grant.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vtg_sel_arb #(
  parameter int WIDTH = 1,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_data,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [WIDTH-1:0] y_data,
  input  logic             y_valid,
  output logic             y_ready,
`ifdef VTG_SEL_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic             sel,
  output logic [WIDTH-1:0] z_data,
  output logic             z_valid,
  input  logic             z_ready
);

  localparam logic [7:0] C_DWELL = 8'(DWELL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_X = 2'd1,
    GRANT_Y = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             r_z_valid;
  logic [WIDTH-1:0] r_z_data;

  logic             w_in_grant;
  logic             w_cur_valid;
  logic             w_oth_valid;
  logic [WIDTH-1:0] w_cur_data;
  logic             w_lock;
  logic             w_sw;
  logic             w_cur_ready;
  logic             w_xfer;

`ifdef VTG_SEL_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // Resolve which source is currently granted ("cur") and which waits ("oth").
  always_comb begin
    w_in_grant  = (r_state == GRANT_X) || (r_state == GRANT_Y);
    w_cur_valid = (r_state == GRANT_Y) ? y_valid : x_valid;
    w_oth_valid = (r_state == GRANT_Y) ? x_valid : y_valid;
    w_cur_data  = (r_state == GRANT_Y) ? y_data  : x_data;
  end

  // The switch cycle is a bubble, so cur is refused whenever sw is raised.
  assign w_sw        = w_in_grant && !w_lock && w_oth_valid &&
                       ((r_cnt == C_DWELL) || !w_cur_valid);
  assign w_cur_ready = w_in_grant && !w_sw && !rst && (!r_z_valid || z_ready);
  assign w_xfer      = w_cur_valid && w_cur_ready;

  assign x_ready = w_cur_ready && (r_state == GRANT_X);
  assign y_ready = w_cur_ready && (r_state == GRANT_Y);
  assign sel     = r_sel;
  assign z_valid = r_z_valid;
  assign z_data  = r_z_data;

  // Next-state, dwell counter and select. IDLE is only ever entered from
  // reset, where the last-granted pointer is Y, so X has priority there.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    case (r_state)
      IDLE: begin
        if (x_valid) begin
          w_state_nxt = GRANT_X;
          w_sel_nxt   = 1'b0;
          w_cnt_nxt   = 8'd0;
        end else if (y_valid) begin
          w_state_nxt = GRANT_Y;
          w_sel_nxt   = 1'b1;
          w_cnt_nxt   = 8'd0;
        end
      end
      GRANT_X, GRANT_Y: begin
        if (w_sw) begin
          w_state_nxt = (r_state == GRANT_X) ? GRANT_Y : GRANT_X;
          w_sel_nxt   = (r_state == GRANT_X);
          w_cnt_nxt   = 8'd0;
        end else if (w_xfer && (r_cnt < C_DWELL)) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = 1'b0;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // One-entry output stage: fill on transfer, drain on z_ready otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z_valid <= 1'b0;
      r_z_data  <= '0;
    end else if (w_xfer) begin
      r_z_valid <= 1'b1;
      r_z_data  <= w_cur_data;
    end else if (z_ready) begin
      r_z_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vtg_sel_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vtg_sel_arb                                             |
// | Description : Directed table-driven bench for vtg_sel_arb (WIDTH=8,      |
// |               DWELL=4). Lock rows are added with VTG_SEL_ARB_LOCK_EN.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vtg_sel_arb;

  localparam int WIDTH = 8;
  localparam int DWELL = 4;
`ifdef VTG_SEL_ARB_LOCK_EN
  localparam logic [7:0] C_S_PRE = 8'h60;
`else
  localparam logic [7:0] C_S_PRE = 8'h00;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x_data;
  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_ready;
  logic             sel;
  logic [WIDTH-1:0] z_data;
  logic             z_valid;
  logic             z_ready;
`ifdef VTG_SEL_ARB_LOCK_EN
  logic             lock;
`endif

  // Free-running clock.
  always #5 clk = ~clk;

  vtg_sel_arb #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .x_data  (x_data),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
`ifdef VTG_SEL_ARB_LOCK_EN
    .lock    (lock),
`endif
    .sel     (sel),
    .z_data  (z_data),
    .z_valid (z_valid),
    .z_ready (z_ready)
  );

  // One cycle of stimulus plus the outputs expected during that cycle
  // (registered outputs reflect the edges before it).
  typedef struct {
    logic       rst;
    logic       xv;
    logic [7:0] xd;
    logic       yv;
    logic [7:0] yd;
    logic       zr;
    logic       lk;
    logic       exr;
    logic       eyr;
    logic       esel;
    logic       ezv;
    logic [7:0] ezd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic xv, input logic [7:0] xd,
                              input logic yv, input logic [7:0] yd, input logic zr,
                              input logic lk, input logic exr, input logic eyr,
                              input logic esel, input logic ezv, input logic [7:0] ezd);
    vec_t v;
    v.rst = r;  v.xv = xv; v.xd = xd; v.yv = yv; v.yd = yd; v.zr = zr; v.lk = lk;
    v.exr = exr; v.eyr = eyr; v.esel = esel; v.ezv = ezv; v.ezd = ezd;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst     = v.rst;
    x_valid = v.xv;
    x_data  = v.xd;
    y_valid = v.yv;
    y_data  = v.yd;
    z_ready = v.zr;
`ifdef VTG_SEL_ARB_LOCK_EN
    lock    = v.lk;
`endif
    #1;
    cmp("x_ready", idx, {7'd0, x_ready}, {7'd0, v.exr});
    cmp("y_ready", idx, {7'd0, y_ready}, {7'd0, v.eyr});
    cmp("sel",     idx, {7'd0, sel},     {7'd0, v.esel});
    cmp("z_valid", idx, {7'd0, z_valid}, {7'd0, v.ezv});
    cmp("z_data",  idx, z_data,          v.ezd);
  endtask

  initial begin
    rst = 1'b1; x_valid = 1'b0; y_valid = 1'b0; z_ready = 1'b1;
    x_data = 8'h00; y_data = 8'h00;
`ifdef VTG_SEL_ARB_LOCK_EN
    lock = 1'b0;
`endif

    //                 rst xv xd    yv yd    zr lk | xr yr sel zv zd
    // Reset with both sources valid.
    vecs.push_back(mk(1, 1, 8'hAA, 1, 8'hBB, 1, 0,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 8'hAA, 1, 8'hBB, 1, 0,  0, 0, 0, 0, 8'h00));
    // X only, streaming 01..05, then X idles with cnt saturated.
    vecs.push_back(mk(0, 1, 8'h01, 0, 8'h00, 1, 0,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h01, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h02, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h01));
    vecs.push_back(mk(0, 1, 8'h03, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h02));
    vecs.push_back(mk(0, 1, 8'h04, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h03));
    vecs.push_back(mk(0, 1, 8'h05, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h04));
    vecs.push_back(mk(0, 0, 8'h05, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h05));
    vecs.push_back(mk(0, 0, 8'h05, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h05));
    // Reset while granted: ready forced low during reset.
    vecs.push_back(mk(1, 1, 8'h10, 1, 8'h20, 1, 0,  0, 0, 0, 0, 8'h05));
    vecs.push_back(mk(1, 1, 8'h10, 1, 8'h20, 1, 0,  0, 0, 0, 0, 8'h00));
    // Both streaming: 10..13, bubble, 20..23, bubble, 14.
    vecs.push_back(mk(0, 1, 8'h10, 1, 8'h20, 1, 0,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h10, 1, 8'h20, 1, 0,  1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h11, 1, 8'h20, 1, 0,  1, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 1, 8'h12, 1, 8'h20, 1, 0,  1, 0, 0, 1, 8'h11));
    vecs.push_back(mk(0, 1, 8'h13, 1, 8'h20, 1, 0,  1, 0, 0, 1, 8'h12));
    vecs.push_back(mk(0, 1, 8'h14, 1, 8'h20, 1, 0,  0, 0, 0, 1, 8'h13));
    vecs.push_back(mk(0, 1, 8'h14, 1, 8'h20, 1, 0,  0, 1, 1, 0, 8'h13));
    vecs.push_back(mk(0, 1, 8'h14, 1, 8'h21, 1, 0,  0, 1, 1, 1, 8'h20));
    vecs.push_back(mk(0, 1, 8'h14, 1, 8'h22, 1, 0,  0, 1, 1, 1, 8'h21));
    vecs.push_back(mk(0, 1, 8'h14, 1, 8'h23, 1, 0,  0, 1, 1, 1, 8'h22));
    vecs.push_back(mk(0, 1, 8'h14, 1, 8'h24, 1, 0,  0, 0, 1, 1, 8'h23));
    vecs.push_back(mk(0, 1, 8'h14, 1, 8'h24, 1, 0,  1, 0, 0, 0, 8'h23));
    vecs.push_back(mk(0, 0, 8'h14, 0, 8'h24, 1, 0,  1, 0, 0, 1, 8'h14));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 8'h14));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 8'h00));
    // Backpressure: z_ready low for 3 cycles after beat 10.
    vecs.push_back(mk(0, 1, 8'h10, 0, 8'h00, 1, 0,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h10, 0, 8'h00, 1, 0,  1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 0,  0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 0,  0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 0,  0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h10));
    vecs.push_back(mk(0, 1, 8'h12, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h11));
    vecs.push_back(mk(0, 0, 8'h12, 0, 8'h00, 1, 0,  1, 0, 0, 1, 8'h12));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 8'h12));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 8'h00));
    // Starvation switch after 2 X beats, then reset with z holding a beat.
    vecs.push_back(mk(0, 1, 8'h30, 1, 8'h40, 1, 0,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h30, 1, 8'h40, 1, 0,  1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h31, 1, 8'h40, 1, 0,  1, 0, 0, 1, 8'h30));
    vecs.push_back(mk(0, 0, 8'h31, 1, 8'h40, 1, 0,  0, 0, 0, 1, 8'h31));
    vecs.push_back(mk(0, 0, 8'h31, 1, 8'h40, 1, 0,  0, 1, 1, 0, 8'h31));
    vecs.push_back(mk(0, 0, 8'h31, 1, 8'h41, 1, 0,  0, 1, 1, 1, 8'h40));
    vecs.push_back(mk(1, 1, 8'h31, 1, 8'h42, 1, 0,  0, 0, 1, 1, 8'h41));
    vecs.push_back(mk(0, 0, 8'h31, 0, 8'h42, 1, 0,  0, 0, 0, 0, 8'h00));
`ifdef VTG_SEL_ARB_LOCK_EN
    // Lock holds X for 8 beats past DWELL; release gives a bubble then Y.
    vecs.push_back(mk(0, 1, 8'h50, 1, 8'h60, 1, 1,  0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h50, 1, 8'h60, 1, 1,  1, 0, 0, 0, 8'h00));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(0, 1, 8'(8'h50 + i), 1, 8'h60, 1, 1, 1, 0, 0, 1, 8'(8'h4F + i)));
    vecs.push_back(mk(0, 1, 8'h58, 1, 8'h60, 1, 0,  0, 0, 0, 1, 8'h57));
    vecs.push_back(mk(0, 1, 8'h58, 1, 8'h60, 1, 0,  0, 1, 1, 0, 8'h57));
    vecs.push_back(mk(0, 0, 8'h58, 0, 8'h61, 1, 0,  0, 1, 1, 1, 8'h60));
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Downstream stall across the switch decision: the switch happens,
    // beat 73 stays in z until drained, then Y resumes with 80.
    apply(mk(1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, C_S_PRE), 1000);
    apply(mk(1, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 8'h00),   1001);
    apply(mk(0, 1, 8'h70, 1, 8'h80, 1, 0,  0, 0, 0, 0, 8'h00),   1002);
    apply(mk(0, 1, 8'h70, 1, 8'h80, 1, 0,  1, 0, 0, 0, 8'h00),   1003);
    apply(mk(0, 1, 8'h71, 1, 8'h80, 1, 0,  1, 0, 0, 1, 8'h70),   1004);
    apply(mk(0, 1, 8'h72, 1, 8'h80, 1, 0,  1, 0, 0, 1, 8'h71),   1005);
    apply(mk(0, 1, 8'h73, 1, 8'h80, 1, 0,  1, 0, 0, 1, 8'h72),   1006);
    apply(mk(0, 1, 8'h74, 1, 8'h80, 0, 0,  0, 0, 0, 1, 8'h73),   1007);
    apply(mk(0, 1, 8'h74, 1, 8'h80, 0, 0,  0, 0, 1, 1, 8'h73),   1008);
    apply(mk(0, 1, 8'h74, 1, 8'h80, 1, 0,  0, 1, 1, 1, 8'h73),   1009);
    apply(mk(0, 1, 8'h74, 1, 8'h81, 1, 0,  0, 1, 1, 1, 8'h80),   1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vtg_sel_arb.md
Name: vtg_sel_arb

Overview:
- Two-source stream arbiter placed directly upstream of vtg_mux.
- Accepts valid/ready streams X and Y and grants one at a time, round-robin, with a minimum dwell of DWELL beats per grant.
- Drives the mux select (sel), so the mux's z reflects the granted source.
- Registers the accepted beat into a one-entry output stage with its own valid/ready handshake.

Parameters:
- WIDTH, 1: data width of x_data, y_data and z_data; 1 matches vtg_mux.
- DWELL, 4: beats a grant must transfer before it may be pre-empted by the other source; legal range 1..255.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- x_data, input, WIDTH: source X payload.
- x_valid, input, 1: source X beat available.
- x_ready, output, 1: block accepts X this cycle.
- y_data, input, WIDTH: source Y payload.
- y_valid, input, 1: source Y beat available.
- y_ready, output, 1: block accepts Y this cycle.
- sel, output, 1: mux select (0 = X, 1 = Y); registered.
- z_data, output, WIDTH: output payload; registered.
- z_valid, output, 1: output beat held.
- z_ready, input, 1: downstream accepts the output beat.
- lock, input, 1: present only with VTG_SEL_ARB_LOCK_EN; freezes the current grant.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, sel=0, z_valid=0, z_data=0, beat count cnt=0.
  - Last-granted pointer = Y, so X wins the first contest.
- States and transitions:
  - IDLE: x_ready=y_ready=0.
    - x_valid → GRANT_X.
    - Else y_valid → GRANT_Y.
    - Both valid → GRANT_X (pointer).
    - Entry takes effect next cycle.
  - GRANT_X / GRANT_Y: the granted source is "cur", the other is "oth".
  - Switch condition sw = oth_valid && (cnt==DWELL || !cur_valid); it is combinational from registered state and inputs.
  - When sw=1, the next state is the other grant, cnt←0 and sel toggles on the same edge.
- Handshake:
  - cur_ready = in_grant && !sw && (!z_valid || z_ready); oth_ready=0.
  - The switch cycle is a single bubble: no beat is accepted from either source.
- Transfer (cur_valid && cur_ready):
  - z_data←cur_data, z_valid←1.
  - cnt←min(cnt+1, DWELL).
- Output stage:
  - z_valid clears on z_ready when no new transfer occurs that cycle.
  - Simultaneous drain and fill keeps z_valid=1 with the new data; full throughput is 1 beat/cycle.
- Stable output: z_data and z_valid are held while z_valid && !z_ready; the sources see ready=0.
- Latency: an accepted beat appears on z_data the next cycle.
- sel timing: sel equals the grant of the beat currently in flight into z. After a switch, z may still hold the old source's beat; sel changes only at the grant edge.
- Boundary conditions:
  - Only cur valid: the grant is held indefinitely and cnt saturates at DWELL.
  - Neither valid: the grant is held; no return to IDLE.
  - Downstream stall across a switch decision: the switch still occurs, no data is lost, and z holds its beat.
  - DWELL=1: with both sources continuously valid the pattern is X, bubble, Y, bubble, and so on.
  - rst mid-packet: immediate return to reset values. Any beat held in z is discarded; source beats not yet accepted are untouched.
- Arithmetic: cnt is 8 bits, saturating, never wraps.

Optional Feature:
- VTG_SEL_ARB_LOCK_EN defined:
  - Adds the lock input. While lock=1 in GRANT_X/GRANT_Y, sw is forced to 0 and the grant is held even if cur is invalid.
  - cnt continues to saturate. When lock falls, normal sw evaluation resumes that cycle.
  - In IDLE, lock is ignored.
- Not defined: no lock port; behaviour is exactly as described above.

Test Plan (WIDTH=8, DWELL=4 unless noted):
- Reset: rst=1 for 2 cycles with all valids high → sel=0, z_valid=0, z_data=0, x_ready=y_ready=0 throughout reset.
- X only, z_ready=1: X streams 0x01..0x05 → GRANT_X, one beat per cycle, z_data=0x01..0x05, each one cycle after acceptance, sel=0.
- Both streaming, z_ready=1: X=0x10.., Y=0x20.. → z sequence 0x10,0x11,0x12,0x13, one bubble, 0x20..0x23, one bubble, 0x14; sel toggles at each bubble.
- Backpressure: z_ready=0 for 3 cycles after the first beat 0x10 → z_data holds 0x10, x_ready=0, no beat lost or duplicated; resumes 0x11 when z_ready=1.
- Starvation switch: X drops valid after 2 beats while Y is valid → switch without waiting for DWELL; next z beats come from Y.
- rst mid-stream with z_valid=1 → next cycle z_valid=0, sel=0, state IDLE.
- (with VTG_SEL_ARB_LOCK_EN) lock=1 while X is granted and both streaming → 8 consecutive X beats, no switch; lock=0 → switch bubble then Y.
